// File: rtl/prog_ctr_if.sv
// Fetch-stage program counter bus: control and target in, current address out.
interface prog_ctr_if #(
  parameter int PC_W = 9
);
  logic            Start;
  logic            Branch;
  logic [PC_W-1:0] Target;
  logic [PC_W-1:0] ProgCtr;

  // Upstream control logic drives restart/branch and observes the PC.
  modport master (
    output Start,
    output Branch,
    output Target,
    input  ProgCtr
  );

  // The program counter samples control and presents the registered address.
  modport slave (
    input  Start,
    input  Branch,
    input  Target,
    output ProgCtr
  );
endinterface

// File: rtl/prog_ctr.sv
// Program counter for the fetch stage: restarts, loads an absolute branch
// target, or advances by one each clock. Output is purely registered so it
// can drive the instruction memory address directly.
module prog_ctr #(
  parameter int PC_W       = 9,
  parameter int START_ADDR = 0
) (
  input  logic     Clk,
  input  logic     RstN,
  prog_ctr_if.slave bus
);

  localparam logic [PC_W-1:0] START_PC = PC_W'(START_ADDR);

  // Increment that wraps at 2^PC_W; no overflow indication by design.
  function automatic logic [PC_W-1:0] wrap_inc(input logic [PC_W-1:0] pc);
    return pc + PC_W'(1);
  endfunction

  logic [PC_W-1:0] pc_p1;
  logic [PC_W-1:0] next_pc_p0;

  // Next-address select: Start beats Branch beats increment. Target is only
  // consulted on the Branch path, so an undriven Target never leaks through.
  always_comb begin
    next_pc_p0 = wrap_inc(pc_p1);
    if (bus.Start)
      next_pc_p0 = START_PC;
    else if (bus.Branch)
      next_pc_p0 = bus.Target;
  end

  // ---- stage p0 -> p1: the single PC register, async-reset to the start address
  always_ff @(posedge Clk or negedge RstN) begin
    if (!RstN)
      pc_p1 <= START_PC;
    else
      pc_p1 <= next_pc_p0;
  end

  assign bus.ProgCtr = pc_p1;

endmodule

// File: tb/tb_prog_ctr.sv
// Self-checking bench for prog_ctr: directed scenarios followed by random
// control traffic, all checked against an arithmetic reference of the PC.
module tb_prog_ctr;

  localparam int PC_W       = 9;
  localparam int START_ADDR = 0;
  localparam int PC_MOD     = 1 << PC_W;

  logic Clk = 1'b0;
  logic RstN;

  prog_ctr_if #(.PC_W(PC_W)) bus ();

  prog_ctr #(
    .PC_W      (PC_W),
    .START_ADDR(START_ADDR)
  ) dut (
    .Clk (Clk),
    .RstN(RstN),
    .bus (bus)
  );

  always #5 Clk = ~Clk;

  int model;
  int n_chk  = 0;
  int n_fail = 0;

  task automatic check(input string tag, input int expv);
    logic [PC_W-1:0] e;
    e = expv[PC_W-1:0];
    n_chk++;
    assert (bus.ProgCtr === e)
      else begin
        n_fail++;
        $error("FAIL %s: ProgCtr=%0d (%b) expected %0d", tag, bus.ProgCtr, bus.ProgCtr, e);
      end
  endtask

  // Reference: what the PC should hold after a rising edge given the
  // inputs present at that edge.
  function automatic int ref_next(input int pc, input logic rst_n, input logic st,
                                  input logic br, input logic [PC_W-1:0] tgt);
    if (!rst_n) return START_ADDR;
    if (st)     return START_ADDR;
    if (br)     return int'(tgt);
    return (pc + 1) % PC_MOD;
  endfunction

  task automatic tick(input string tag);
    @(posedge Clk);
    model = ref_next(model, RstN, bus.Start, bus.Branch, bus.Target);
    #1;
    check(tag, model);
  endtask

  initial begin
    // Reset held with a branch pending: PC must sit at the start address.
    RstN       = 1'b0;
    bus.Start  = 1'b0;
    bus.Branch = 1'b1;
    bus.Target = 9'd100;
    model      = START_ADDR;
    #2;
    check("reset_immediate", START_ADDR);
    for (int i = 0; i < 3; i++) tick("reset_held");

    RstN       = 1'b1;
    bus.Branch = 1'b0;
    for (int i = 0; i < 3; i++) tick("count_after_reset");
    check("count_reaches_3", 3);

    // Start restart from PC = 5.
    for (int i = 0; i < 2; i++) tick("run_to_5");
    check("at_5", 5);
    bus.Start = 1'b1;
    tick("start_pulse");
    check("start_gives_0", 0);
    bus.Start = 1'b0;
    tick("after_start_1");
    tick("after_start_2");
    check("after_start_is_2", 2);
    bus.Start = 1'b1;
    for (int i = 0; i < 3; i++) tick("start_held");
    check("start_held_0", 0);
    bus.Start = 1'b0;

    // Branch load at PC = 7.
    for (int i = 0; i < 7; i++) tick("run_to_7");
    check("at_7", 7);
    bus.Branch = 1'b1;
    bus.Target = 9'd100;
    tick("branch_load");
    check("branch_100", 100);
    bus.Branch = 1'b0;
    tick("post_branch_101");
    tick("post_branch_102");
    check("post_branch_is_102", 102);

    // Branch held, then target changes while held.
    bus.Branch = 1'b1;
    bus.Target = 9'd100;
    for (int i = 0; i < 5; i++) tick("branch_held");
    check("branch_held_100", 100);
    bus.Target = 9'd40;
    tick("branch_retarget");
    check("retarget_40", 40);
    bus.Branch = 1'b0;
    tick("post_retarget_41");
    tick("post_retarget_42");
    check("post_retarget_is_42", 42);

    // Priority and wrap.
    bus.Start  = 1'b1;
    bus.Branch = 1'b1;
    bus.Target = 9'd200;
    tick("start_beats_branch");
    check("start_beats_branch_0", 0);
    bus.Start  = 1'b0;
    bus.Target = 9'd511;
    tick("branch_to_max");
    check("at_511", 511);
    bus.Branch = 1'b0;
    tick("wrap");
    check("wrap_to_0", 0);
    bus.Branch = 1'b1;
    tick("branch_to_max_again");
    bus.Target = 9'd3;
    tick("branch_beats_wrap");
    check("branch_beats_wrap_3", 3);

    // Undriven target while not branching must not disturb the count.
    bus.Branch = 1'b0;
    bus.Target = 'x;
    for (int i = 0; i < 3; i++) tick("x_target_ignored");
    bus.Start = 1'b1;
    tick("x_target_with_start");
    bus.Start = 1'b0;

    // Asynchronous reset pulse mid-run at PC = 150.
    bus.Branch = 1'b1;
    bus.Target = 9'd148;
    tick("branch_148");
    bus.Branch = 1'b0;
    tick("run_149");
    tick("run_150");
    check("at_150", 150);
    bus.Branch = 1'b1;
    bus.Target = 9'd77;
    @(negedge Clk);
    RstN = 1'b0;
    #1;
    model = START_ADDR;
    check("async_reset_midcycle", 0);
    #1;
    RstN       = 1'b1;
    bus.Branch = 1'b0;
    tick("post_async_1");
    tick("post_async_2");
    check("post_async_is_2", 2);

    // Random control traffic with occasional mid-cycle reset pulses.
    for (int i = 0; i < 400; i++) begin
      bus.Start  = ($urandom_range(0, 9) == 0);
      bus.Branch = ($urandom_range(0, 3) == 0);
      bus.Target = PC_W'($urandom_range(0, PC_MOD - 1));
      if ($urandom_range(0, 49) == 0) begin
        @(negedge Clk);
        RstN = 1'b0;
        #1;
        model = START_ADDR;
        check("rand_async_reset", model);
        #1;
        RstN = 1'b1;
      end
      tick("random");
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
